// File: rtl/bip_cpu_core.sv
// bip_cpu_core: multi-cycle accumulator CPU (FETCH -> EXEC [-> MEMRD] -> FETCH, absorbing HALT).
// Define BIP_CYCLE_COUNT_EN to add the saturating 16-bit cycle counter output o_cycles.
module bip_cpu_core #(
  parameter int PC_BITS      = 11,
  parameter int ADDRESS_BITS = 5,
  parameter int DATA_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [PC_BITS-1:0]      o_pm_addr,
  output logic                    o_pm_read,
  input  logic [15:0]             i_instr,
  output logic [ADDRESS_BITS-1:0] o_dm_addr,
  output logic                    o_dm_read,
  output logic                    o_dm_write,
  output logic [DATA_BITS-1:0]    o_dm_data,
  input  logic [DATA_BITS-1:0]    i_dm_data,
  output logic [DATA_BITS-1:0]    o_acc,
  output logic                    o_halt
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [15:0]             o_cycles
`endif
);

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEMRD = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [PC_BITS-1:0]     pc_reg, pc_next;
  logic [DATA_BITS-1:0]   acc_reg, acc_next;
  logic [4:0]             op_reg, op_next;

  logic                    pm_read;
  logic                    dm_read;
  logic                    dm_write;
  logic [ADDRESS_BITS-1:0] dm_addr;

  logic [4:0]           opcode;
  logic [10:0]          operand;
  logic [DATA_BITS-1:0] imm;
  logic                 unused_operand;

  assign opcode         = i_instr[15:11];
  assign operand        = i_instr[10:0];
  assign imm            = operand[DATA_BITS-1:0];
  assign unused_operand = ^operand;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= FETCH;
      pc_reg    <= '0;
      acc_reg   <= '0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      acc_reg   <= acc_next;
      op_reg    <= op_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    acc_next   = acc_reg;
    op_next    = op_reg;
    pm_read    = 1'b0;
    dm_read    = 1'b0;
    dm_write   = 1'b0;
    dm_addr    = '0;
    case (state_reg)
      FETCH: begin
        pm_read    = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        dm_addr    = operand[ADDRESS_BITS-1:0];
        state_next = FETCH;
        pc_next    = pc_reg + PC_BITS'(1);
        case (opcode)
          OP_HLT: begin
            state_next = HALT;
            pc_next    = pc_reg;
          end
          OP_STO:  dm_write = 1'b1;
          OP_LDI:  acc_next = imm;
          OP_ADDI: acc_next = acc_reg + imm;
          OP_SUBI: acc_next = acc_reg - imm;
          OP_LD, OP_ADD, OP_SUB: begin
            // PC advances only once the memory operand has been consumed in MEMRD
            dm_read    = 1'b1;
            op_next    = opcode;
            state_next = MEMRD;
            pc_next    = pc_reg;
          end
          default: ;
        endcase
      end
      MEMRD: begin
        state_next = FETCH;
        pc_next    = pc_reg + PC_BITS'(1);
        case (op_reg)
          OP_LD:   acc_next = i_dm_data;
          OP_ADD:  acc_next = acc_reg + i_dm_data;
          OP_SUB:  acc_next = acc_reg - i_dm_data;
          default: ;
        endcase
      end
      HALT: ;
      default: state_next = FETCH;
    endcase
  end

  // Data memory strobes are masked during reset so a mid-instruction reset never touches memory
  assign o_dm_read  = dm_read & rst;
  assign o_dm_write = dm_write & rst;
  assign o_dm_addr  = dm_addr;
  assign o_pm_read  = pm_read;
  assign o_pm_addr  = pc_reg;
  assign o_dm_data  = acc_reg;
  assign o_acc      = acc_reg;
  assign o_halt     = (state_reg == HALT);

`ifdef BIP_CYCLE_COUNT_EN
  logic [15:0] cycles_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycles_reg <= '0;
    end else if ((state_reg != HALT) && (cycles_reg != 16'hFFFF)) begin
      cycles_reg <= cycles_reg + 16'd1;
    end
  end

  assign o_cycles = cycles_reg;
`endif

endmodule

// File: tb/tb_bip_cpu_core.sv
// Directed testbench for bip_cpu_core with behavioural program and data memories.
// Checks o_cycles as well when BIP_CYCLE_COUNT_EN is defined.
module tb_bip_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] o_pm_addr;
  logic        o_pm_read;
  logic [15:0] i_instr;
  logic [4:0]  o_dm_addr;
  logic        o_dm_read;
  logic        o_dm_write;
  logic [7:0]  o_dm_data;
  logic [7:0]  i_dm_data;
  logic [7:0]  o_acc;
  logic        o_halt;
`ifdef BIP_CYCLE_COUNT_EN
  logic [15:0] o_cycles;
`endif

  logic [15:0] pm [0:2047];
  logic [7:0]  dm [0:31];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, nrd, nwr, nboth;

  bip_cpu_core dut (
    .clk        (clk),
    .rst        (rst),
    .o_pm_addr  (o_pm_addr),
    .o_pm_read  (o_pm_read),
    .i_instr    (i_instr),
    .o_dm_addr  (o_dm_addr),
    .o_dm_read  (o_dm_read),
    .o_dm_write (o_dm_write),
    .o_dm_data  (o_dm_data),
    .i_dm_data  (i_dm_data),
    .o_acc      (o_acc),
    .o_halt     (o_halt)
`ifdef BIP_CYCLE_COUNT_EN
    ,
    .o_cycles   (o_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous memories: read data is valid one cycle after the strobe
  always @(posedge clk) begin
    if (o_pm_read) i_instr <= pm[o_pm_addr];
    if (o_dm_write) dm[o_dm_addr] <= o_dm_data;
    if (o_dm_read) i_dm_data <= dm[o_dm_addr];
  end

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opd);
    return {op, opd};
  endfunction

  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2048; i++) pm[i] = 16'h0000;
    for (int i = 0; i < 32; i++) dm[i] = 8'h00;
  endtask

  // Releases reset on a falling edge and counts rising edges until HALT is observed
  task automatic run_to_halt();
    rst   = 1'b1;
    cyc   = 0;
    nrd   = 0;
    nwr   = 0;
    nboth = 0;
    while (!o_halt && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (o_dm_read) nrd++;
      if (o_dm_write) nwr++;
      if (o_dm_read && o_dm_write) nboth++;
    end
  endtask

  task automatic test_reset();
    enter_reset();
    n_checks++; if (o_pm_addr !== 11'd0) begin n_fail++; $display("FAIL rst_pm_addr: got %0h expected 0", o_pm_addr); end
    n_checks++; if (o_pm_read !== 1'b1) begin n_fail++; $display("FAIL rst_pm_read: got %b expected 1", o_pm_read); end
    n_checks++; if (o_dm_addr !== 5'd0) begin n_fail++; $display("FAIL rst_dm_addr: got %0h expected 0", o_dm_addr); end
    n_checks++; if (o_dm_read !== 1'b0) begin n_fail++; $display("FAIL rst_dm_read: got %b expected 0", o_dm_read); end
    n_checks++; if (o_dm_write !== 1'b0) begin n_fail++; $display("FAIL rst_dm_write: got %b expected 0", o_dm_write); end
    n_checks++; if (o_dm_data !== 8'd0) begin n_fail++; $display("FAIL rst_dm_data: got %0h expected 0", o_dm_data); end
    n_checks++; if (o_acc !== 8'd0) begin n_fail++; $display("FAIL rst_acc: got %0h expected 0", o_acc); end
    n_checks++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %b expected 0", o_halt); end
`ifdef BIP_CYCLE_COUNT_EN
    n_checks++; if (o_cycles !== 16'd0) begin n_fail++; $display("FAIL rst_cycles: got %0d expected 0", o_cycles); end
`endif
    $display("test_reset done");
  endtask

  task automatic test_program();
    int bad;
    enter_reset();
    pm[0] = ins(5'b00011, 11'd5);
    pm[1] = ins(5'b00001, 11'd3);
    pm[2] = ins(5'b00101, 11'd2);
    pm[3] = ins(5'b00100, 11'd3);
    pm[4] = ins(5'b00111, 11'd1);
    pm[5] = ins(5'b00000, 11'd0);
    run_to_halt();
    n_checks++; if (o_halt !== 1'b1) begin n_fail++; $display("FAIL prog_halt: got %b expected 1", o_halt); end
    n_checks++; if (cyc !== 13) begin n_fail++; $display("FAIL prog_latency: got %0d expected 13", cyc); end
    n_checks++; if (o_acc !== 8'd11) begin n_fail++; $display("FAIL prog_acc: got %0d expected 11", o_acc); end
    n_checks++; if (dm[3] !== 8'd5) begin n_fail++; $display("FAIL prog_mem3: got %0d expected 5", dm[3]); end
    n_checks++; if (o_pm_addr !== 11'd5) begin n_fail++; $display("FAIL prog_pc: got %0d expected 5", o_pm_addr); end
    n_checks++; if (nwr !== 1 || nrd !== 1 || nboth !== 0) begin n_fail++; $display("FAIL prog_strobes: got wr=%0d rd=%0d both=%0d expected 1 1 0", nwr, nrd, nboth); end
`ifdef BIP_CYCLE_COUNT_EN
    n_checks++; if (o_cycles !== 16'd13) begin n_fail++; $display("FAIL prog_cycles: got %0d expected 13", o_cycles); end
`endif
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_pm_read !== 1'b0 || o_dm_read !== 1'b0 || o_dm_write !== 1'b0 ||
          o_acc !== 8'd11 || o_pm_addr !== 11'd5 || o_halt !== 1'b1) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL halt_frozen: got %0d bad cycles expected 0", bad); end
`ifdef BIP_CYCLE_COUNT_EN
    n_checks++; if (o_cycles !== 16'd13) begin n_fail++; $display("FAIL halt_cycles: got %0d expected 13", o_cycles); end
`endif
    $display("test_program done: acc=%0d pc=%0d cycles=%0d", o_acc, o_pm_addr, cyc);
  endtask

  task automatic test_wrap();
    enter_reset();
    pm[0] = ins(5'b00011, 11'h0FF);
    pm[1] = ins(5'b00101, 11'h701);
    run_to_halt();
    n_checks++; if (o_acc !== 8'h00 || o_halt !== 1'b1) begin n_fail++; $display("FAIL addi_wrap: got acc=%0h halt=%b expected 00 1", o_acc, o_halt); end
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL addi_latency: got %0d expected 6", cyc); end
    enter_reset();
    pm[0] = ins(5'b00011, 11'h000);
    pm[1] = ins(5'b00111, 11'h001);
    run_to_halt();
    n_checks++; if (o_acc !== 8'hFF || o_halt !== 1'b1) begin n_fail++; $display("FAIL subi_wrap: got acc=%0h halt=%b expected ff 1", o_acc, o_halt); end
    $display("test_wrap done");
  endtask

  task automatic test_memops();
    enter_reset();
    pm[0] = ins(5'b00011, 11'h042);
    pm[1] = ins(5'b00001, 11'h7E7);
    pm[2] = ins(5'b00011, 11'h001);
    pm[3] = ins(5'b00110, 11'h007);
    run_to_halt();
    n_checks++; if (o_acc !== 8'hBF) begin n_fail++; $display("FAIL sub_mem: got %0h expected bf", o_acc); end
    n_checks++; if (dm[7] !== 8'h42) begin n_fail++; $display("FAIL sto_addr: got %0h expected 42", dm[7]); end
    n_checks++; if (cyc !== 11) begin n_fail++; $display("FAIL sub_latency: got %0d expected 11", cyc); end
    enter_reset();
    dm[7] = 8'h9C;
    pm[0] = ins(5'b00010, 11'h007);
    pm[1] = ins(5'b00100, 11'h007);
    run_to_halt();
    n_checks++; if (o_acc !== 8'h38) begin n_fail++; $display("FAIL ld_add: got %0h expected 38", o_acc); end
    n_checks++; if (cyc !== 8 || nrd !== 2 || nwr !== 0) begin n_fail++; $display("FAIL ld_add_timing: got cyc=%0d rd=%0d wr=%0d expected 8 2 0", cyc, nrd, nwr); end
    $display("test_memops done");
  endtask

  task automatic test_nop();
    enter_reset();
    pm[0] = ins(5'b11111, 11'h0AA);
    pm[1] = ins(5'b00011, 11'h009);
    run_to_halt();
    n_checks++; if (nrd !== 0 || nwr !== 0) begin n_fail++; $display("FAIL nop_strobes: got rd=%0d wr=%0d expected 0 0", nrd, nwr); end
    n_checks++; if (o_acc !== 8'h09 || o_pm_addr !== 11'd2) begin n_fail++; $display("FAIL nop_advance: got acc=%0h pc=%0d expected 09 2", o_acc, o_pm_addr); end
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL nop_latency: got %0d expected 6", cyc); end
    $display("test_nop done");
  endtask

  task automatic test_reset_mid();
    enter_reset();
    dm[4] = 8'h11;
    pm[0] = ins(5'b00011, 11'h055);
    pm[1] = ins(5'b00001, 11'h004);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (o_dm_write !== 1'b1 || o_dm_addr !== 5'd4) begin n_fail++; $display("FAIL sto_exec: got wr=%b addr=%0d expected 1 4", o_dm_write, o_dm_addr); end
    rst = 1'b0;
    #1;
    n_checks++; if (o_dm_write !== 1'b0) begin n_fail++; $display("FAIL rst_gate_write: got %b expected 0", o_dm_write); end
    @(negedge clk);
    n_checks++; if (dm[4] !== 8'h11) begin n_fail++; $display("FAIL rst_mem_kept: got %0h expected 11", dm[4]); end
    n_checks++; if (o_pm_addr !== 11'd0 || o_acc !== 8'd0) begin n_fail++; $display("FAIL rst_restart: got pc=%0d acc=%0h expected 0 0", o_pm_addr, o_acc); end
    run_to_halt();
    n_checks++; if (o_acc !== 8'h55 || dm[4] !== 8'h55) begin n_fail++; $display("FAIL rerun: got acc=%0h mem4=%0h expected 55 55", o_acc, dm[4]); end
    $display("test_reset_mid done");
  endtask

  task automatic test_pc_wrap();
    enter_reset();
    for (int i = 0; i < 2047; i++) pm[i] = ins(5'b11111, 11'h000);
    pm[2047] = ins(5'b00011, 11'h021);
    rst = 1'b1;
    repeat (4094) @(negedge clk);
    n_checks++; if (o_pm_addr !== 11'h7FF) begin n_fail++; $display("FAIL pc_top: got %0h expected 7ff", o_pm_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (o_pm_addr !== 11'd0 || o_acc !== 8'h21 || o_halt !== 1'b0) begin n_fail++; $display("FAIL pc_wrap: got pc=%0h acc=%0h halt=%b expected 0 21 0", o_pm_addr, o_acc, o_halt); end
    $display("test_pc_wrap done");
  endtask

  initial begin
    test_reset();
    test_program();
    test_wrap();
    test_memops();
    test_nop();
    test_reset_mid();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bip_cpu_core.md
BIP_CPU_CORE -- requirements
Module: bip_cpu_core

Interface
REQ-001 SHALL have parameter PC_BITS, default 11: program counter and program address width.
REQ-002 SHALL have parameter ADDRESS_BITS, default 5: data memory address width.
REQ-003 SHALL have parameter DATA_BITS, default 8: accumulator and data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-low reset.
REQ-006 SHALL have port o_pm_addr  output  PC_BITS  program memory address, always equal to PC.
REQ-007 SHALL have port o_pm_read  output  1  program memory read strobe.
REQ-008 SHALL have port i_instr  input  16  instruction word, valid 1 cycle after o_pm_read; opcode [15:11], operand [10:0].
REQ-009 SHALL have port o_dm_addr  output  ADDRESS_BITS  data memory address, operand[ADDRESS_BITS-1:0] in EXEC, else 0.
REQ-010 SHALL have port o_dm_read  output  1  data memory read strobe.
REQ-011 SHALL have port o_dm_write  output  1  data memory write strobe.
REQ-012 SHALL have port o_dm_data  output  DATA_BITS  store data, always equal to ACC.
REQ-013 SHALL have port i_dm_data  input  DATA_BITS  load data, valid 1 cycle after o_dm_read.
REQ-014 SHALL have port o_acc  output  DATA_BITS  accumulator value.
REQ-015 SHALL have port o_halt  output  1  high while in HALT.

Function
REQ-016 SHALL implement FSM states FETCH, EXEC, MEMRD, HALT; strobes are combinational decodes of state and i_instr.
REQ-017 FETCH SHALL assert o_pm_read for exactly one cycle, then go to EXEC.
REQ-018 EXEC SHALL decode i_instr: HLT=00000 -> HALT; STO=00001 -> o_dm_write=1, PC+1, FETCH; LDI=00011 -> ACC=imm, PC+1, FETCH.
REQ-019 EXEC SHALL decode ADDI=00101 as ACC+imm and SUBI=00111 as ACC-imm, each with PC+1 and a return to FETCH.
REQ-020 EXEC SHALL decode LD=00010, ADD=00100 and SUB=00110 as o_dm_read=1, latch the opcode, and go to MEMRD.
REQ-021 MEMRD SHALL apply the latched operation: LD ACC=i_dm_data; ADD ACC+i_dm_data; SUB ACC-i_dm_data; then PC+1 and FETCH.
REQ-022 Any undefined opcode SHALL execute as a NOP: PC+1, FETCH, no strobes.
REQ-023 imm SHALL be operand[DATA_BITS-1:0]; all arithmetic SHALL wrap modulo 2^DATA_BITS, with no flags.
REQ-024 PC SHALL wrap from 2^PC_BITS-1 to 0.
REQ-025 o_dm_read and o_dm_write SHALL never be high in the same cycle, and SHALL each be at most one cycle per instruction.
REQ-026 HALT SHALL be absorbing until reset: no strobes, and PC and ACC frozen.
REQ-027 Instruction latency SHALL be 2 cycles for HLT, STO, LDI, ADDI, SUBI and NOP, and 3 cycles for LD, ADD and SUB.

Reset
REQ-028 While rst=0 at a clock edge: state SHALL become FETCH, PC 0, ACC 0, latched opcode 0.
REQ-029 Reset values SHALL be: o_pm_addr 0, o_pm_read 1, o_dm_addr 0, o_dm_read 0, o_dm_write 0, o_dm_data 0, o_acc 0, o_halt 0.
REQ-030 o_dm_read and o_dm_write SHALL be gated by rst, so no data memory access issues in any cycle with rst=0, including mid-instruction.

Configuration
REQ-031 Macro BIP_CYCLE_COUNT_EN defined SHALL add port o_cycles  output  16.
REQ-032 o_cycles SHALL increment on each edge with rst=1 and state not HALT, freeze in HALT, saturate at 0xFFFF, and reset to 0.
REQ-033 Macro BIP_CYCLE_COUNT_EN undefined SHALL remove o_cycles and all counter logic, with all other behaviour identical.

Verification
REQ-034 Program LDI 5; STO 3; ADDI 2; ADD 3; SUBI 1; HLT SHALL end with o_acc=11, mem[3]=5, o_halt=1 and PC=5.
REQ-035 The same program with BIP_CYCLE_COUNT_EN SHALL give o_cycles=13 at HALT entry, unchanged 20 cycles later.
REQ-036 LDI 0xFF; ADDI 1 SHALL give o_acc=0x00; LDI 0; SUBI 1 SHALL give o_acc=0xFF (wrap).
REQ-037 rst driven low during the EXEC of STO SHALL give o_dm_write=0 in that cycle, mem unchanged, and restart at PC=0 with o_acc=0.
REQ-038 Opcode 11111 SHALL give no strobes and PC+1; a HLT fetched SHALL keep o_pm_read=0 and o_dm_* strobes 0 forever.
